// File: rtl/error_if.sv
// Data/control bundle for the error-injection stage.
// The master side (pattern generator and controller) drives the word and controls.
// The slave side (the injector) returns the possibly corrupted word and its status.
interface error_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       mode;
    logic [WIDTH-1:0] mask;
    logic             inject;
    logic [15:0]      period;
    logic [7:0]       threshold;
    logic             err_flag;
    logic [CNT_W-1:0] err_count;

    modport master (
        output A, mode, mask, inject, period, threshold,
        input  B, err_flag, err_count
    );

    modport slave (
        input  A, mode, mask, inject, period, threshold,
        output B, err_flag, err_count
    );
endinterface

// File: rtl/error.sv
// Error-injection stage of the BER tester.
// Each word passes through with one clock of latency. Selected words have the
// bits of an error mask flipped, chosen by a single-shot, periodic or LFSR-random
// policy. A saturating counter tallies every bit flipped, so the downstream
// checker's count can be compared against it.
module error #(
    parameter int          WIDTH     = 8,
    parameter int          CNT_W     = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    error_if.slave bus
);
    typedef enum logic [1:0] {
        M_OFF      = 2'b00,
        M_SINGLE   = 2'b01,
        M_PERIODIC = 2'b10,
        M_RANDOM   = 2'b11
    } mode_e;

    logic [WIDTH-1:0] b_q;
    logic             flag_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      wcnt_q, wcnt_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             inj_q;
    logic             pending_q, pending_d;
    logic             first_q;

    logic [WIDTH-1:0] emask;
    logic             inj_edge;
    logic [CNT_W:0]   pop;
    logic [CNT_W:0]   sum;
    int unsigned      bitpos;

    assign inj_edge = bus.inject & ~inj_q;

    // Feedback from taps 16,14,13,11 (bits 15,13,12,10); the register shifts every clock.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Choose this word's error mask and the next state of the policy counters.
    always_comb begin
        emask     = '0;
        wcnt_d    = '0;
        pending_d = 1'b0;
        bitpos    = 32'(lfsr_q[10:8]) % WIDTH;
        case (mode_e'(bus.mode))
            M_SINGLE: begin
                // A set pending bit means this word is the one to corrupt. The pending
                // bit clears here, but an edge in the same cycle arms it again.
                if (pending_q) emask = bus.mask;
                pending_d = inj_edge;
            end
            M_PERIODIC: begin
                if (bus.period != 16'd0 && wcnt_q == bus.period - 16'd1) begin
                    emask  = bus.mask;
                    wcnt_d = '0;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            M_RANDOM: begin
                if (lfsr_q[7:0] < bus.threshold) emask = WIDTH'(1) << bitpos;
            end
            default: ;
        endcase
        // The first word after reset always passes through clean.
        if (first_q) emask = '0;
    end

    // Saturating bit-error tally.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + (CNT_W+1)'(emask[i]);
        sum   = {1'b0, cnt_q} + pop;
        cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    // Registered datapath and state; reset takes priority over all other activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q       <= '0;
            flag_q    <= 1'b0;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            lfsr_q    <= LFSR_SEED;
            inj_q     <= 1'b0;
            pending_q <= 1'b0;
            first_q   <= 1'b1;
        end else begin
            b_q       <= bus.A ^ emask;
            flag_q    <= |emask;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            lfsr_q    <= lfsr_d;
            inj_q     <= bus.inject;
            pending_q <= pending_d;
            first_q   <= 1'b0;
        end
    end

    assign bus.B         = b_q;
    assign bus.err_flag  = flag_q;
    assign bus.err_count = cnt_q;
endmodule

// File: tb/tb_error.sv
// Directed bench for the error-injection stage: pass-through, single-shot,
// periodic, random-mode bounds, reset mid-run and counter saturation on a
// 4-bit-counter build.
module tb_error;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    error_if #(.WIDTH(8), .CNT_W(32)) bus ();
    error_if #(.WIDTH(8), .CNT_W(4))  sbus ();

    error #(.WIDTH(8), .CNT_W(32), .LFSR_SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    error #(.WIDTH(8), .CNT_W(4), .LFSR_SEED(16'hACE1)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] c0;
    int          flagged;
    int          pc;

    initial begin
        rst = 1'b1;
        bus.A = '0; bus.mode = 2'b00; bus.mask = '0; bus.inject = 1'b0;
        bus.period = '0; bus.threshold = '0;
        sbus.A = '0; sbus.mode = 2'b00; sbus.mask = '0; sbus.inject = 1'b0;
        sbus.period = '0; sbus.threshold = '0;
        step(); step();
        check("rst_B", 32'(bus.B), 32'h0);
        check("rst_flag", 32'(bus.err_flag), 32'h0);
        check("rst_cnt", bus.err_count, 32'h0);
        rst = 1'b0;

        // pass-through, including a negative value
        bus.A = 8'd8;    step(); check("off_8", 32'(bus.B), 32'd8);
        bus.A = 8'd100;  step(); check("off_100", 32'(bus.B), 32'd100);
        bus.A = 8'd250;  step(); check("off_250", 32'(bus.B), 32'd250);
        bus.A = 8'd0;    step(); check("off_0", 32'(bus.B), 32'd0);
        bus.A = -8'sd5;  step(); check("off_neg5", 32'(bus.B), 32'hFB);
        check("off_cnt", bus.err_count, 32'd0);

        // single-shot: inject held high three cycles still gives one error
        bus.mode = 2'b01; bus.mask = 8'h80; bus.A = 8'd100;
        step(); check("ss_idle", 32'(bus.B), 32'h64);
        bus.inject = 1'b1;
        step(); check("ss_arm", 32'(bus.B), 32'h64);
        step(); check("ss_hit", 32'(bus.B), 32'hE4);
        check("ss_flag", 32'(bus.err_flag), 32'h1);
        check("ss_cnt", bus.err_count, 32'd1);
        step(); check("ss_after", 32'(bus.B), 32'h64);
        check("ss_flag0", 32'(bus.err_flag), 32'h0);
        bus.inject = 1'b0;
        step(); check("ss_low", 32'(bus.B), 32'h64);
        check("ss_cnt1", bus.err_count, 32'd1);

        // periodic, period 4: every 4th word gets 2 bits flipped
        bus.mode = 2'b10; bus.period = 16'd4; bus.mask = 8'h03; bus.A = 8'h00;
        for (int w = 1; w <= 8; w++) begin
            step();
            check($sformatf("per_B%0d", w), 32'(bus.B), (w % 4 == 0) ? 32'h03 : 32'h00);
            check($sformatf("per_f%0d", w), 32'(bus.err_flag), (w % 4 == 0) ? 32'h1 : 32'h0);
        end
        check("per_cnt", bus.err_count, 32'd5);

        // periodic with mask 0: selected but not flagged, count unchanged
        bus.period = 16'd1; bus.mask = 8'h00;
        step(); step();
        check("m0_flag", 32'(bus.err_flag), 32'h0);
        check("m0_cnt", bus.err_count, 32'd5);

        // period 0 never corrupts
        bus.period = 16'd0; bus.mask = 8'hFF;
        for (int w = 0; w < 6; w++) step();
        check("p0_cnt", bus.err_count, 32'd5);

        // random, threshold 0: never corrupts
        bus.mode = 2'b11; bus.threshold = 8'd0; bus.A = 8'h55;
        for (int w = 0; w < 10; w++) begin
            step();
            check("rnd0_B", 32'(bus.B), 32'h55);
        end
        check("rnd0_cnt", bus.err_count, 32'd5);

        // random, threshold 255: at most one bit per word, count tracks flags
        bus.threshold = 8'd255;
        c0 = bus.err_count;
        flagged = 0;
        step();
        for (int w = 0; w < 20; w++) begin
            pc = $countones(bus.B ^ 8'h55);
            check("rnd_1bit", 32'(pc <= 1), 32'h1);
            check("rnd_flag", 32'(bus.err_flag), 32'(pc == 1));
            if (bus.err_flag) flagged++;
            step();
        end
        if (bus.err_flag) flagged++;
        check("rnd_some", 32'(flagged > 0), 32'h1);
        check("rnd_cnt", bus.err_count - c0, 32'(flagged));

        // periodic run, then reset mid-operation
        bus.mode = 2'b10; bus.period = 16'd4; bus.mask = 8'h03; bus.A = 8'h00;
        step(); step();
        rst = 1'b1;
        step();
        check("mrst_B", 32'(bus.B), 32'h0);
        check("mrst_cnt", bus.err_count, 32'd0);
        rst = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            step();
            check($sformatf("mrst_B%0d", w), 32'(bus.B), (w == 4) ? 32'h03 : 32'h00);
        end
        check("mrst_cnt2", bus.err_count, 32'd2);

        // saturation on the 4-bit-counter build: 8 bits flipped per word
        sbus.mode = 2'b10; sbus.period = 16'd1; sbus.mask = 8'hFF; sbus.A = 8'h0F;
        step(); check("sat_B", 32'(sbus.B), 32'hF0);
        check("sat_8", 32'(sbus.err_count), 32'd8);
        step(); check("sat_15a", 32'(sbus.err_count), 32'd15);
        step(); check("sat_15b", 32'(sbus.err_count), 32'd15);
        step(); check("sat_15c", 32'(sbus.err_count), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
